// File: rtl/mul_req_arbiter.sv
// Round-robin share of one pipelined signed multiplier among N requesters; results routed back in issue order.
// Optional MUL_REQ_ARBITER_PERF_EN adds saturating per-requester issue counters and a stall counter.
module mul_req_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  output logic [N-1:0]    resp_valid,
  input  logic [N-1:0]    resp_ready,
  output logic [63:0]     resp_data,
  output logic            mul_valid_o,
  input  logic            mul_ready_i,
  output logic [31:0]     mul_data1,
  output logic [31:0]     mul_data2,
  input  logic            mul_valid_i,
  output logic            mul_ready_o,
  input  logic [63:0]     mul_res,
  output logic            err_orphan
`ifdef MUL_REQ_ARBITER_PERF_EN
  ,
  output logic [N*16-1:0] perf_issue,
  output logic [15:0]     perf_stall
`endif
);

  localparam int TAGW = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  typedef enum logic {ARB, HOLD} state_t;

  state_t          state;
  logic [TAGW-1:0] rr_ptr, grant_r, sel, cand, cur, head;
  logic            found, cur_vld, full, empty, push, pop;
  logic [TAGW-1:0] tag_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

  // First valid requester after the last winner, wrapping modulo N.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = TAGW'((int'(rr_ptr) + k) % N);
      if (!found && req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign cur         = (state == HOLD) ? grant_r : sel;
  assign cur_vld     = (state == HOLD) ? req_valid[grant_r] : found;
  assign mul_valid_o = cur_vld & ~full;
  assign push        = mul_valid_o & mul_ready_i;

  always_comb begin
    mul_data1 = '0;
    mul_data2 = '0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (cur == TAGW'(i)) begin
        mul_data1    = req_a[32*i +: 32];
        mul_data2    = req_b[32*i +: 32];
        req_ready[i] = mul_valid_o & mul_ready_i;
      end
    end
  end

  // With no tag outstanding the multiplier output is drained so a stray result cannot wedge it.
  always_comb begin
    resp_valid = '0;
    if (!empty) resp_valid[head] = mul_valid_i;
  end

  assign mul_ready_o = empty | resp_ready[head];
  assign resp_data   = mul_res;
  assign pop         = ~empty & mul_valid_i & mul_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      rr_ptr  <= TAGW'(N - 1);
      grant_r <= '0;
    end else begin
      case (state)
        ARB: begin
          if (mul_valid_o) begin
            if (mul_ready_i) begin
              rr_ptr <= sel;
            end else begin
              grant_r <= sel;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!req_valid[grant_r]) begin
            state <= ARB;
          end else if (push) begin
            rr_ptr <= grant_r;
            state  <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      if (empty && mul_valid_i) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= cur;
  end

`ifdef MUL_REQ_ARBITER_PERF_EN
  logic stall_ev;
  assign stall_ev = (mul_valid_o & ~mul_ready_i) | (full & (|req_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push && cur == TAGW'(i) && perf_issue[16*i +: 16] != 16'hFFFF)
          perf_issue[16*i +: 16] <= perf_issue[16*i +: 16] + 16'd1;
      end
      if (stall_ev && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_req_arbiter.sv
// Scoreboard bench for mul_req_arbiter driving a 4-stage elastic multiplier model.
module tb_mul_req_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [63:0]     resp_data, mul_res;
  logic            mul_valid_o, mul_ready_i, mul_valid_i, mul_ready_o, err_orphan;
  logic [31:0]     mul_data1, mul_data2;
`ifdef MUL_REQ_ARBITER_PERF_EN
  logic [N*16-1:0] perf_issue;
  logic [15:0]     perf_stall;
`endif

  mul_req_arbiter #(.N(N), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i),
    .mul_data1(mul_data1), .mul_data2(mul_data2),
    .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o), .mul_res(mul_res),
    .err_orphan(err_orphan)
`ifdef MUL_REQ_ARBITER_PERF_EN
    , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
  );

  // Multiplier model: four-stage elastic pipeline, stage 3 drives the result.
  logic        mul_stall, orphan_inj;
  logic [3:0]  st_v;
  logic [63:0] st_d [4];
  logic        adv0, adv1, adv2, adv3;
  logic [63:0] prod;

  assign prod        = {{32{mul_data1[31]}}, mul_data1} * {{32{mul_data2[31]}}, mul_data2};
  assign adv3        = ~st_v[3] | mul_ready_o;
  assign adv2        = ~st_v[2] | adv3;
  assign adv1        = ~st_v[1] | adv2;
  assign adv0        = ~st_v[0] | adv1;
  assign mul_ready_i = ~mul_stall & adv0;
  assign mul_valid_i = st_v[3] | orphan_inj;
  assign mul_res     = st_d[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v <= '0;
    end else begin
      if (adv3) begin st_v[3] <= st_v[2]; st_d[3] <= st_d[2]; end
      if (adv2) begin st_v[2] <= st_v[1]; st_d[2] <= st_d[1]; end
      if (adv1) begin st_v[1] <= st_v[0]; st_d[1] <= st_d[0]; end
      if (adv0) begin st_v[0] <= mul_valid_o & mul_ready_i; st_d[0] <= prod; end
    end
  end

  typedef struct { logic [N-1:0] oh; logic [31:0] a; logic [31:0] b; } iss_t;
  typedef struct { logic [N-1:0] oh; logic [63:0] d; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];
  iss_t mi;
  rsp_t mr;

  int checks = 0, failures = 0, mon_checks = 0, mon_fails = 0;

  // Monitor: compares issue handshakes and presented results against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mul_valid_o && mul_ready_i) begin
        mon_checks++;
        if (iss_q.size() == 0) begin
          mon_fails++;
          $display("FAIL issue_unexpected: got oh=%b a=%h b=%h want none", req_ready, mul_data1, mul_data2);
        end else begin
          mi = iss_q.pop_front();
          if (req_ready !== mi.oh || mul_data1 !== mi.a || mul_data2 !== mi.b) begin
            mon_fails++;
            $display("FAIL issue: got oh=%b a=%h b=%h want oh=%b a=%h b=%h",
                     req_ready, mul_data1, mul_data2, mi.oh, mi.a, mi.b);
          end
        end
      end
      if (resp_valid != '0) begin
        mon_checks++;
        if (rsp_q.size() == 0) begin
          mon_fails++;
          $display("FAIL resp_unexpected: got valid=%b data=%h want none", resp_valid, resp_data);
        end else begin
          mr = rsp_q[0];
          if (resp_valid !== mr.oh || resp_data !== mr.d) begin
            mon_fails++;
            $display("FAIL resp: got valid=%b data=%h want valid=%b data=%h",
                     resp_valid, resp_data, mr.oh, mr.d);
          end
          if ((resp_valid & resp_ready) != '0) void'(rsp_q.pop_front());
        end
      end
    end
  end

  logic [31:0] op_a [N][8];
  logic [31:0] op_b [N][8];
  int          cnt [N];
  int          pos [N];
  logic [N-1:0] hs;
  int          accepted;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic exp_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [63:0] d);
    iss_t e;
    rsp_t x;
    e.oh = N'(1) << r; e.a = a; e.b = b;
    x.oh = N'(1) << r; x.d = d;
    iss_q.push_back(e);
    rsp_q.push_back(x);
  endtask

  task automatic load(input int r, input int n);
    cnt[r] = n;
    pos[r] = 0;
    req_a[32*r +: 32] = op_a[r][0];
    req_b[32*r +: 32] = op_b[r][0];
    req_valid[r] = 1'b1;
  endtask

  // Sample handshakes at the negedge, advance operands just after the posedge.
  task automatic step();
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    accepted += $countones(hs);
    for (int r = 0; r < N; r++) begin
      if (hs[r]) begin
        pos[r]++;
        if (pos[r] >= cnt[r]) begin
          req_valid[r] = 1'b0;
        end else begin
          req_a[32*r +: 32] = op_a[r][pos[r]];
          req_b[32*r +: 32] = op_b[r][pos[r]];
        end
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(iss_q.size() + rsp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    mul_stall = 1'b0;
    orphan_inj = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    accepted = 0;
  endtask

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = '1;
    mul_stall = 1'b0; orphan_inj = 1'b0; rst_n = 1'b0; hs = '0; accepted = 0;

    do_reset();
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mul_valid", 64'(mul_valid_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mul_ready_o", 64'(mul_ready_o), 64'd1);
    chk("rst_err_orphan", 64'(err_orphan), 64'd0);

    // Single signed op from requester 1: 3 * -2.
    op_a[1][0] = 32'd3; op_b[1][0] = 32'hFFFF_FFFE;
    exp_op(1, 32'd3, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA);
    load(1, 1);
    wait_drain("single_drain", 60);

    // Fairness: all four requesters hold valid, two ops each.
    do_reset();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 2; k++) begin
        op_a[r][k] = 32'(r + 1);
        op_b[r][k] = 32'd10;
      end
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N; r++) exp_op(r, 32'(r + 1), 32'd10, 64'((r + 1) * 10));
    for (int r = 0; r < N; r++) load(r, 2);
    wait_drain("fair_drain", 120);
`ifdef MUL_REQ_ARBITER_PERF_EN
    #2 chk("perf_issue", 64'(perf_issue), 64'h0002_0002_0002_0002);
`endif

    // Full FIFO: six requests with results held back; exactly four issue.
    do_reset();
    resp_ready = '0;
    for (int k = 0; k < 6; k++) begin
      op_a[2][k] = 32'(k + 1);
      op_b[2][k] = 32'd7;
      exp_op(2, 32'(k + 1), 32'd7, 64'((k + 1) * 7));
    end
    load(2, 6);
    repeat (12) step();
    #2;
    chk("full_accepted", 64'(accepted), 64'd4);
    chk("full_req_ready", 64'(req_ready), 64'd0);
    chk("full_mul_valid", 64'(mul_valid_o), 64'd0);
    chk("full_mul_ready_o", 64'(mul_ready_o), 64'd0);
    resp_ready = '1;
    wait_drain("full_drain", 100);
    chk("full_accepted_all", 64'(accepted), 64'd6);

    // HOLD: multiplier stalled while 0 and 2 request; grant and operands stay on 0.
    do_reset();
    mul_stall = 1'b1;
    op_a[0][0] = 32'd5; op_b[0][0] = 32'd6;
    op_a[2][0] = 32'd7; op_b[2][0] = 32'd8;
    exp_op(0, 32'd5, 32'd6, 64'd30);
    exp_op(2, 32'd7, 32'd8, 64'd56);
    load(0, 1);
    load(2, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      #2;
      chk("hold_mul_valid", 64'(mul_valid_o), 64'd1);
      chk("hold_data1", 64'(mul_data1), 64'd5);
      chk("hold_data2", 64'(mul_data2), 64'd6);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    mul_stall = 1'b0;
    wait_drain("hold_drain", 60);
`ifdef MUL_REQ_ARBITER_PERF_EN
    #2 chk("perf_stall", 64'(perf_stall), 64'd3);
`endif

    // Head-of-line: requester 0 refuses its result, requester 1 must wait behind it.
    do_reset();
    resp_ready = 4'b1110;
    op_a[0][0] = 32'd2; op_b[0][0] = 32'd3;
    op_a[1][0] = 32'd4; op_b[1][0] = 32'd5;
    exp_op(0, 32'd2, 32'd3, 64'd6);
    exp_op(1, 32'd4, 32'd5, 64'd20);
    load(0, 1);
    load(1, 1);
    repeat (6) step();
    for (int c = 0; c < 5; c++) begin
      step();
      #2;
      chk("hol_mul_ready_o", 64'(mul_ready_o), 64'd0);
      chk("hol_resp_valid", 64'(resp_valid), 64'b0001);
    end
    resp_ready = '1;
    wait_drain("hol_drain", 60);

    // Orphan: stray result with nothing outstanding; sticky until reset.
    orphan_inj = 1'b1;
    step();
    #2 chk("orphan_set", 64'(err_orphan), 64'd1);
    orphan_inj = 1'b0;
    repeat (3) step();
    #2 chk("orphan_sticky", 64'(err_orphan), 64'd1);
    do_reset();
    #2 chk("orphan_cleared", 64'(err_orphan), 64'd0);

    repeat (2) @(posedge clk);
    checks   = checks + mon_checks;
    failures = failures + mon_fails;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_req_arbiter.md
Name: mul_req_arbiter

Overview:
- Shares one pipelined 32x32 signed Booth multiplier (valid/ready on both sides, up to 4 operations in flight) between N requesters.
- Round-robin arbitration on the issue side.
- A tag FIFO records which requester owns each in-flight operation, so each 64-bit result goes back to its owner in issue order.
- Sits between the core-side functional units and the multiplier; adds zero cycles of latency on either path.

Parameters:
- N, 4, number of requesters (2..8).
- DEPTH, 4, tag FIFO depth = maximum in-flight operations; must be ≥ multiplier pipeline occupancy.
- TAGW, clog2(N), requester tag width (derived, localparam).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N  per-requester operation valid
- req_ready  out  N  per-requester accept
- req_a  in  N*32  operand 1, requester i at [32i+31:32i]
- req_b  in  N*32  operand 2
- resp_valid  out  N  one-hot result valid
- resp_ready  in  N  per-requester result accept
- resp_data  out  64  result, broadcast to all requesters
- mul_valid_o  out  1  to multiplier valid_i
- mul_ready_i  in  1  from multiplier ready_o
- mul_data1  out  32  to multiplier data1
- mul_data2  out  32  to multiplier data2
- mul_valid_i  in  1  from multiplier valid_o
- mul_ready_o  out  1  to multiplier ready_i
- mul_res  in  64  from multiplier res
- err_orphan  out  1  sticky: a result arrived with no tag outstanding

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - state=ARB, rr_ptr=N-1, grant_r=0.
  - Tag FIFO empty: rd/wr pointers 0, count=0.
  - err_orphan=0.
  - All outputs are combinational from this state, so req_ready=0, mul_valid_o=0, resp_valid=0.
- Issue FSM, state ARB:
  - Requires count<DEPTH.
  - Selects the first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, … modulo N.
  - Drives mul_valid_o=1, mul_data1=req_a[i], mul_data2=req_b[i], req_ready[i]=mul_ready_i.
  - If mul_ready_i=1: push tag i into the FIFO, set rr_ptr=i, stay in ARB.
  - If mul_ready_i=0: set grant_r=i and go to HOLD.
- Issue FSM, state HOLD:
  - Grant is locked to grant_r; no re-arbitration.
  - Mirrors req_valid[grant_r] onto mul_valid_o; operands come from grant_r.
  - On handshake: push the tag, set rr_ptr=grant_r, return to ARB.
  - Requesters must keep valid until accepted. If req_valid[grant_r] drops anyway, return to ARB with no push.
- FIFO full (count==DEPTH): mul_valid_o=0 and all req_ready=0. A pop in the same cycle does not enable a push; there is no bypass.
- Response path, FIFO not empty:
  - Head tag t selects the destination.
  - resp_valid[t]=mul_valid_i; resp_data=mul_res; mul_ready_o=resp_ready[t].
  - Pop on mul_valid_i & mul_ready_o.
- Response path, FIFO empty:
  - resp_valid=0 and mul_ready_o=1, so stray results drain.
  - If mul_valid_i=1 in this condition, set err_orphan; it clears only on reset.
- Simultaneous push and pop: count unchanged; both pointers advance and wrap modulo DEPTH.
- Ordering: results return strictly in issue order across all requesters. A stalled owner (resp_ready=0) back-pressures the multiplier and blocks every later result.
- resp_data is not held once the handshake completes.
- Reset mid-operation: FSM and FIFO clear immediately. In-flight multiplier results that arrive after reset count as orphans unless the multiplier is reset on the same rst_n (the normal case).

Optional Feature:
- Macro: MUL_REQ_ARBITER_PERF_EN.
- When defined:
  - Adds output perf_issue  N*16: per-requester count of issue handshakes.
  - Adds output perf_stall  16: cycles with mul_valid_o & ~mul_ready_i, plus cycles with some req_valid while the FIFO is full.
  - All counters saturate at 0xFFFF and reset to 0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Single op: requester 1 issues a=3, b=0xFFFFFFFE, resp_ready=1 → resp_valid=4'b0010 and resp_data=0xFFFFFFFFFFFFFFFA after the multiplier latency; all other resp_valid bits stay 0.
- Fairness: all 4 requesters hold valid continuously with a=i+1, b=10 → grant order 0,1,2,3,0…; results 10,20,30,40 return to requesters 0..3 in that order.
- Full FIFO: resp_ready=0 everywhere, 6 back-to-back requests → exactly 4 accepted, then req_ready=0 and mul_valid_o=0. After raising resp_ready, 4 results drain, and 2 more issue only once count<4.
- HOLD lock: mul_ready_i=0 for 3 cycles while requesters 0 and 2 are valid → grant stays on 0, and operands stay stable all 3 cycles. When ready rises, 0 is accepted and the next grant is 2.
- Head-of-line blocking: issue from 0 then 1, hold resp_ready[0]=0 for 5 cycles → mul_ready_o=0, and requester 1 sees no resp_valid until requester 0's result is taken.
- Orphan: pulse mul_valid_i with the FIFO empty → err_orphan=1 and stays 1 until rst_n is asserted. With MUL_REQ_ARBITER_PERF_EN, perf_issue for the fairness test reads 1 per requester after 4 issues.
